// File: rtl/spi_cmd_tx.sv
// SPI mode-0 master that serialises {HDR, addr, sdata} commands into 24-bit
// frames for the ADC. It captures MISO into a readback register and holds
// one pending command so that a request arriving mid-frame is not lost.
module spi_cmd_tx #(
  parameter int         CLKDIV = 4,
  parameter logic [3:0] HDR    = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ctrlen,
  input  logic [3:0]  addr,
  input  logic [15:0] sdata,
  output logic        spi_sclk,
  output logic        spi_cs_n,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        busy,
  output logic        done,
  output logic        ovf,
  output logic [15:0] rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_HOLD,
    S_GAP
  } state_t;

  localparam logic [8:0] HALF        = 9'(CLKDIV);
  localparam logic [8:0] HALF_LAST   = 9'(CLKDIV - 1);
  localparam logic [8:0] PERIOD_LAST = 9'(2 * CLKDIV - 1);

  state_t      state, state_n;
  logic [8:0]  cnt;
  logic [4:0]  bit_cnt;
  logic [23:0] tx_sr;
  logic [15:0] rx_sr;
  logic [15:0] rdata_q;
  logic        ctrlen_q;
  logic        slot_valid;
  logic [23:0] slot_frame;
  logic        ovf_q;

  logic        req;
  logic [23:0] req_frame;
  logic        phase_last;
  logic        sclk_fall;
  logic        bit_end;
  logic        gap_last;
  logic        hold_last;
  logic        slot_load;
  logic        launch;
  logic [23:0] launch_frame;

  assign req        = ctrlen & ~ctrlen_q;
  assign req_frame  = {HDR, addr, sdata};
  assign phase_last = (cnt == HALF_LAST);
  // The clk edge that ends the high half of sclk: sample MISO, advance MOSI.
  assign sclk_fall  = (state == S_SHIFT) && phase_last;
  assign bit_end    = (state == S_SHIFT) && (cnt == PERIOD_LAST);
  assign gap_last   = (state == S_GAP) && phase_last;
  assign hold_last  = (state == S_HOLD) && phase_last;

  // A request in the last GAP cycle with an empty slot launches directly
  // instead of parking in the slot.
  assign slot_load  = req && (state != S_IDLE) && !(gap_last && !slot_valid);

  assign spi_cs_n = !((state == S_SETUP) || (state == S_SHIFT) || (state == S_HOLD));
  assign spi_sclk = (state == S_SHIFT) && (cnt < HALF);
  assign spi_mosi = tx_sr[23];
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_GAP) && (cnt == 9'd0);
  assign ovf      = ovf_q;
  assign rdata    = rdata_q;

  // Next-state logic and frame launch selection.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_n      = state;
    launch       = 1'b0;
    launch_frame = req_frame;
    case (state)
      S_IDLE: begin
        if (req) begin
          state_n = S_SETUP;
          launch  = 1'b1;
        end
      end
      S_SETUP: begin
        if (phase_last) state_n = S_SHIFT;
      end
      S_SHIFT: begin
        if (bit_end && (bit_cnt == 5'd23)) state_n = S_HOLD;
      end
      S_HOLD: begin
        if (phase_last) state_n = S_GAP;
      end
      S_GAP: begin
        if (gap_last) begin
          if (slot_valid) begin
            state_n      = S_SETUP;
            launch       = 1'b1;
            launch_frame = slot_frame;
          end else if (req) begin
            state_n = S_SETUP;
            launch  = 1'b1;
          end else begin
            state_n = S_IDLE;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register, phase counter and bit counter.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state    <= S_IDLE;
      cnt      <= 9'd0;
      bit_cnt  <= 5'd0;
      ctrlen_q <= 1'b0;
    end else begin
      state    <= state_n;
      ctrlen_q <= ctrlen;
      if ((state_n != state) || bit_end || (state == S_IDLE)) cnt <= 9'd0;
      else                                                   cnt <= cnt + 9'd1;
      if (state != S_SHIFT) bit_cnt <= 5'd0;
      else if (bit_end)     bit_cnt <= bit_cnt + 5'd1;
    end
  end

  // Transmit/receive shift registers and readback capture.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_sr   <= 24'd0;
      rx_sr   <= 16'd0;
      rdata_q <= 16'd0;
    end else begin
      if (launch)         tx_sr <= launch_frame;
      else if (sclk_fall) tx_sr <= {tx_sr[22:0], 1'b0};
      if (sclk_fall) rx_sr <= {rx_sr[14:0], spi_miso};
      if (hold_last) rdata_q <= rx_sr;
    end
  end

  // Single-entry pending command slot with overwrite flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      slot_valid <= 1'b0;
      // NOTE: the slot payload is reset too, so a stale command can never leak out after reset.
      slot_frame <= 24'd0;
      ovf_q      <= 1'b0;
    end else begin
      ovf_q <= slot_load && slot_valid && !gap_last;
      if (slot_load) begin
        slot_valid <= 1'b1;
        slot_frame <= req_frame;
      end else if (gap_last && slot_valid) begin
        slot_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spi_cmd_tx.sv
// Directed bench for spi_cmd_tx with CLKDIV=4: single frame, full duplex,
// back-to-back, overflow, level hold, reset abort, request at reset release.
`timescale 1ns/1ps
module tb_spi_cmd_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ctrlen = 1'b0;
  logic [3:0]  addr = 4'h0;
  logic [15:0] sdata = 16'h0;
  logic        spi_miso = 1'b0;
  logic        spi_sclk, spi_cs_n, spi_mosi, busy, done, ovf;
  logic [15:0] rdata;

  int checks = 0;
  int errors = 0;

  spi_cmd_tx #(.CLKDIV(4), .HDR(4'h0)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ctrlen   (ctrlen),
    .addr     (addr),
    .sdata    (sdata),
    .spi_sclk (spi_sclk),
    .spi_cs_n (spi_cs_n),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .busy     (busy),
    .done     (done),
    .ovf      (ovf),
    .rdata    (rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Mode-0 slave: first bit on cs fall, next bit after each sclk fall.
  logic [23:0] slave_resp = 24'h0;
  int          sl_idx = 0;
  logic        sl_active = 1'b0;
  always @(spi_cs_n or negedge spi_sclk) begin
    if (spi_cs_n) begin
      sl_active = 1'b0;
      spi_miso  = 1'b0;
    end else if (!sl_active) begin
      sl_active = 1'b1;
      sl_idx    = 23;
      spi_miso  = slave_resp[23];
    end else if (!spi_sclk) begin
      sl_idx   = sl_idx - 1;
      spi_miso = (sl_idx >= 0) ? slave_resp[sl_idx] : 1'b0;
    end
  end

  // Bus monitor sampled on the falling clk edge.
  int          cyc = 0;
  logic        prev_cs = 1'b1;
  logic        prev_sclk = 1'b0;
  int          cs_len = 0, rise_n = 0, last_len = 0, last_rises = 0;
  logic [23:0] mosi_acc = 24'h0;
  int          frame_cnt = 0, done_cnt = 0, ovf_cnt = 0, busy_low = 0;
  logic [23:0] mosi_log [16];
  int          cs_fall_log [16];
  int          cs_rise_log [16];

  always @(negedge clk) begin
    cyc       <= cyc + 1;
    prev_cs   <= spi_cs_n;
    prev_sclk <= spi_sclk;
    if (!spi_cs_n) begin
      if (prev_cs) begin
        cs_len                      <= 1;
        rise_n                      <= 0;
        mosi_acc                    <= 24'h0;
        cs_fall_log[frame_cnt % 16] <= cyc;
      end else begin
        cs_len <= cs_len + 1;
        if (spi_sclk && !prev_sclk) begin
          rise_n   <= rise_n + 1;
          mosi_acc <= {mosi_acc[22:0], spi_mosi};
        end
      end
    end else if (!prev_cs) begin
      frame_cnt                   <= frame_cnt + 1;
      last_len                    <= cs_len;
      last_rises                  <= rise_n;
      mosi_log[frame_cnt % 16]    <= mosi_acc;
      cs_rise_log[frame_cnt % 16] <= cyc;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (ovf)  ovf_cnt  <= ovf_cnt + 1;
    if (!busy) busy_low <= busy_low + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic request(input logic [3:0] a, input logic [15:0] d, output int t);
    @(negedge clk);
    addr   = a;
    sdata  = d;
    ctrlen = 1'b1;
    t      = cyc;
    @(negedge clk);
    ctrlen = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        at = cyc;
        break;
      end
    end
    check({tag, "_seen"}, {31'd0, done}, 32'd1);
  endtask

  int c0, c1, f0, f1, d0, o0, b0, at;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ctl", {26'd0, spi_cs_n, spi_sclk, spi_mosi, busy, done, ovf}, 32'b100000);
    check("rst_rdata", {16'd0, rdata}, 32'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single frame with full-duplex readback
    slave_resp = 24'h00BEEF;
    f0 = frame_cnt;
    request(4'h3, 16'hA5C3, c0);
    wait_done("t1_done", 300, at);
    check("t1_done_cyc", at - c0, 201);
    check("t1_rdata", {16'd0, rdata}, 32'h0000BEEF);
    repeat (3) @(negedge clk);
    check("t1_busy_gap_end", {31'd0, busy}, 32'd1);
    @(negedge clk);
    check("t1_busy_low", {31'd0, busy}, 32'd0);
    repeat (5) @(negedge clk);
    check("t1_cs_len", last_len, 200);
    check("t1_rises", last_rises, 24);
    check("t1_mosi", {8'd0, mosi_log[f0 % 16]}, 32'h0003A5C3);
    check("t1_frames", frame_cnt - f0, 1);
    repeat (20) @(negedge clk);
    check("t1_rdata_hold", {16'd0, rdata}, 32'h0000BEEF);

    // Back-to-back: second request mid-SHIFT of the first
    slave_resp = 24'h123456;
    f0 = frame_cnt; d0 = done_cnt; o0 = ovf_cnt;
    request(4'h2, 16'h2222, c0);
    repeat (58) @(negedge clk);
    request(4'h1, 16'h1111, c1);
    repeat (3) @(negedge clk);
    b0 = busy_low;
    wait_done("t2_done_a", 300, at);
    check("t2_done_a_cyc", at - c0, 201);
    wait_done("t2_done_b", 300, at);
    check("t2_done_b_cyc", at - c0, 405);
    check("t2_busy_held", busy_low - b0, 0);
    repeat (10) @(negedge clk);
    check("t2_no_ovf", ovf_cnt - o0, 0);
    check("t2_dones", done_cnt - d0, 2);
    check("t2_cs_gap", cs_fall_log[(f0 + 1) % 16] - cs_rise_log[f0 % 16], 4);
    check("t2_mosi_a", {8'd0, mosi_log[f0 % 16]}, 32'h00022222);
    check("t2_mosi_b", {8'd0, mosi_log[(f0 + 1) % 16]}, 32'h00011111);
    check("t2_rdata", {16'd0, rdata}, 32'h00003456);

    // Overflow: three requests inside one frame
    slave_resp = 24'h000F0F;
    f0 = frame_cnt; d0 = done_cnt; o0 = ovf_cnt;
    request(4'h0, 16'h0001, c0);
    repeat (28) @(negedge clk);
    request(4'h0, 16'h0002, c1);
    repeat (28) @(negedge clk);
    request(4'h0, 16'h0003, c1);
    wait_done("t3_done_a", 300, at);
    wait_done("t3_done_b", 300, at);
    repeat (220) @(negedge clk);
    check("t3_ovf", ovf_cnt - o0, 1);
    check("t3_frames", frame_cnt - f0, 2);
    check("t3_dones", done_cnt - d0, 2);
    check("t3_mosi_a", {8'd0, mosi_log[f0 % 16]}, 32'h00000001);
    check("t3_mosi_b", {8'd0, mosi_log[(f0 + 1) % 16]}, 32'h00000003);
    check("t3_idle", {31'd0, busy}, 32'd0);

    // Level hold: one frame per rising edge of ctrlen
    f0 = frame_cnt;
    @(negedge clk);
    addr = 4'h5; sdata = 16'h5555; ctrlen = 1'b1;
    repeat (500) @(negedge clk);
    check("t4_one_frame", frame_cnt - f0, 1);
    ctrlen = 1'b0;
    @(negedge clk);
    ctrlen = 1'b1;
    repeat (250) @(negedge clk);
    ctrlen = 1'b0;
    repeat (5) @(negedge clk);
    check("t4_two_frames", frame_cnt - f0, 2);
    check("t4_mosi_b", {8'd0, mosi_log[(f0 + 1) % 16]}, 32'h00055555);

    // Reset abort at bit 10 of SHIFT with a command pending
    d0 = done_cnt;
    request(4'h6, 16'h6666, c0);
    repeat (37) @(negedge clk);
    request(4'h7, 16'h7777, c1);
    while (cyc < c0 + 88) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_ctl", {28'd0, spi_cs_n, spi_sclk, busy, done}, 32'b1000);
    check("t5_rdata", {16'd0, rdata}, 32'd0);
    repeat (2) @(negedge clk);
    f1 = frame_cnt;
    repeat (300) @(negedge clk);
    check("t5_no_frame", frame_cnt - f1, 0);
    check("t5_no_done", done_cnt - d0, 0);
    check("t5_idle", {31'd0, busy}, 32'd0);

    // ctrlen already high when reset is released counts as a request
    @(negedge clk);
    rst_n = 1'b0;
    addr = 4'h8; sdata = 16'h8888; ctrlen = 1'b1;
    repeat (2) @(negedge clk);
    f0 = frame_cnt;
    rst_n = 1'b1;
    c0 = cyc;
    wait_done("t6_done", 300, at);
    check("t6_done_cyc", at - c0, 201);
    ctrlen = 1'b0;
    repeat (10) @(negedge clk);
    check("t6_mosi", {8'd0, mosi_log[f0 % 16]}, 32'h00088888);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/spi_cmd_tx.md
Name: spi_cmd_tx

Overview:
- Serial back end for the command generator's outputs. Consumes the ctrlen/addr/sdata command triple and shifts a 24-bit SPI frame out to the ADC.
- Operates as SPI master, mode 0 (sclk idle low, MOSI changes on sclk fall, data sampled on sclk rise). Full duplex: captures MISO into a readback register.
- Holds one pending command so a request arriving mid-frame is not lost.

Parameters:
- CLKDIV, 4, clk cycles per sclk half-period; legal range 2..255.
- HDR, 4'h0, 4-bit frame header sent before addr.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous, active-low reset.
- ctrlen  in  1  command request; level input, a request is its rising edge.
- addr  in  4  register address; sampled on the request cycle.
- sdata  in  16  register data; sampled on the request cycle.
- spi_sclk  out  1  SPI clock.
- spi_cs_n  out  1  SPI chip select, active low.
- spi_mosi  out  1  serial data out, MSB first.
- spi_miso  in  1  serial data in.
- busy  out  1  high while a frame or gap is in progress.
- done  out  1  one-cycle pulse at frame end.
- ovf  out  1  one-cycle pulse when a pending command is overwritten.
- rdata  out  16  last 16 MISO bits of the most recent frame.

Behaviour:
- Reset (sampled at posedge with rst_n=0):
  - Outputs: spi_cs_n=1, spi_sclk=0, spi_mosi=0, busy=0, done=0, ovf=0, rdata=0.
  - Internal: state=IDLE, pending slot cleared, ctrlen history register=0.
  - Reset mid-frame aborts immediately with no done pulse.
  - A ctrlen already high when reset is released counts as a new request.
- Request detection:
  - req = ctrlen & ~ctrlen_q, where ctrlen_q is ctrlen registered.
  - {HDR, addr, sdata} is latched in the request cycle.
- Frame format: frame[23:0] = {HDR, addr, sdata}; bit 23 is sent first.
- State machine:
  - IDLE:
    - req at cycle T -> SETUP at T+1; spi_cs_n=0, spi_mosi=frame[23], busy=1.
  - SETUP:
    - Lasts CLKDIV cycles, spi_sclk=0.
  - SHIFT:
    - 24 bit periods of 2*CLKDIV cycles each.
    - First half: spi_sclk=1. Second half: spi_sclk=0.
    - spi_miso is captured into the shift register on the clk edge that drives spi_sclk 1->0.
    - On that same edge spi_mosi advances to the next bit; after bit 0 it drives 0.
  - HOLD:
    - CLKDIV cycles, spi_cs_n=0, spi_sclk=0.
  - GAP:
    - CLKDIV cycles, spi_cs_n=1, busy=1.
    - On the first GAP cycle: done=1 and rdata is updated with the 16 LSBs received.
- Timing totals:
  - spi_cs_n is low for exactly 50*CLKDIV cycles.
  - Request edge to done: 50*CLKDIV+1 cycles.
- After GAP:
  - If the pending slot is valid (or req occurs in the last GAP cycle): go to SETUP on the next cycle and clear the slot. busy stays high.
  - Otherwise go to IDLE, busy=0.
- Pending slot:
  - req while state != IDLE loads the slot.
  - If the slot is already valid, the newest command overwrites it and ovf pulses for 1 cycle.
  - If req arrives in the last GAP cycle while the slot is valid, the slot's command launches and the new command enters the slot (no ovf).
- ctrlen held high produces exactly one request. It must return low for at least 1 cycle to re-arm.

Test Plan:
- CLKDIV=4: ctrlen rises with addr=4'h3, sdata=16'hA5C3 ->
  - spi_cs_n low 200 cycles.
  - 24 sclk rises.
  - MOSI stream 0x03A5C3 MSB first.
  - done at cycle T+201, busy low after 4 GAP cycles.
- Full duplex: spi_miso driven as a slave in mode 0 returning 24'h00BEEF -> rdata=16'hBEEF on the done cycle; rdata holds until the next frame.
- Back-to-back:
  - Second request (addr=1, sdata=16'h1111) arrives mid-SHIFT of the first.
  - Required: no ovf, second frame's spi_cs_n falls exactly CLKDIV cycles after the first's rises, busy stays high throughout, two done pulses.
- Overflow: three requests (sdata 1, 2, 3) during one frame -> ovf pulses once (at the third); frames sent carry sdata 1 then 3; sdata 2 is never sent.
- Level hold: ctrlen held high 500 cycles -> exactly one frame. Drop ctrlen 1 cycle, then raise it -> a second frame.
- Reset abort: rst_n low for 1 cycle at bit 10 of SHIFT ->
  - Next cycle: spi_cs_n=1, spi_sclk=0, busy=0, no done, rdata=0.
  - Pending slot is empty; no frame starts until a fresh request.
